fft_frame_ctrl: RTL and testbench
=================================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 10, bits per real/imag component; a complex sample is 2*NBITS bits.
REQ-002 SHALL have parameter N, default 8, FFT length; power of two, >=4; one frame = N/2 sample pairs.
REQ-003 SHALL have parameter LATENCY, default 6, topfft input-to-output pipeline depth in cycles, >=1.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, permits frame acceptance.
REQ-007 SHALL have port clr, input, 1, synchronous discard of a partially filled frame.
REQ-008 SHALL have port s_valid, input, 1, the upstream pair is valid.
REQ-009 SHALL have port s_ready, output, 1, the block accepts the pair this cycle.
REQ-010 SHALL have port s_up, input, 2*NBITS, even-index sample.
REQ-011 SHALL have port s_down, input, 2*NBITS, odd-index sample.
REQ-012 SHALL have port fft_in_up, output, 2*NBITS, registered drive to topfft fftIn_up.
REQ-013 SHALL have port fft_in_down, output, 2*NBITS, registered drive to topfft fftIn_down.
REQ-014 SHALL have port fft_out_up, input, 2*NBITS, from topfft fftOut_up.
REQ-015 SHALL have port fft_out_down, input, 2*NBITS, from topfft fftOut_down.
REQ-016 SHALL have ports m_up and m_down, output, 2*NBITS each, combinational pass-through of fft_out_up and fft_out_down.
REQ-017 SHALL have ports m_valid, m_sof and m_eof, output, 1 each, result-pair qualifiers.
REQ-018 SHALL have port frame_cnt, output, 8, count of completed output frames.
REQ-019 SHALL have port busy, output, 1, burst in progress or results pending.

Function
REQ-020 SHALL hold a frame buffer of N/2 entries, each storing the pair {s_up, s_down}, with write pointer wr_ptr and read pointer rd_ptr, each log2(N/2) bits wide.
REQ-021 SHALL implement two states: FILL and BURST.
REQ-022 SHALL drive s_ready = (state==FILL) && en && !clr.
REQ-023 In FILL, s_valid&&s_ready SHALL write buf[wr_ptr] and increment wr_ptr; writing index N/2-1 SHALL move the state to BURST with rd_ptr=0 and wr_ptr=0.
REQ-024 In FILL, clr SHALL zero wr_ptr and discard buffered pairs; clr together with s_valid SHALL perform no write.
REQ-025 In BURST, clr and en SHALL be ignored, and the burst SHALL always run N/2 consecutive cycles.
REQ-026 In BURST, each cycle SHALL register buf[rd_ptr] into fft_in_up/fft_in_down and increment rd_ptr; at rd_ptr==N/2-1 the state SHALL return to FILL.
REQ-027 Outside BURST cycles, fft_in_up/fft_in_down SHALL register zero.
REQ-028 Each fft_in register stage SHALL carry a tag {v, sof, eof}: v=1 in burst cycles, sof=1 for rd_ptr==0, eof=1 for rd_ptr==N/2-1.
REQ-029 The tag SHALL pass through a LATENCY-stage shift register; its last stage SHALL drive m_valid, m_sof and m_eof, aligned with the topfft result for that input.
REQ-030 frame_cnt SHALL increment on each m_valid&&m_eof and SHALL wrap from 255 to 0.
REQ-031 busy SHALL be high in BURST, or while any tag stage holds v=1.
REQ-032 A new frame SHALL be accepted while previous results drain; the tag pipeline never stalls, and the sink has no backpressure.
REQ-033 Minimum frame period SHALL be N cycles: N/2 for FILL plus N/2 for BURST.

Reset
REQ-034 While rst is low, the block SHALL hold state FILL, both pointers at 0, fft_in_up/fft_in_down at 0, all tag stages at 0, and frame_cnt at 0; m_valid, m_sof, m_eof and busy SHALL be 0.
REQ-035 Reset asserted mid-BURST or mid-drain SHALL abandon the frame, and no m_valid SHALL follow.
REQ-036 Buffer contents SHALL need no reset.

Verification
REQ-037 Reset release, en=1, s_valid held high with pairs 1..4 on N=8 -> s_ready high for 4 cycles, then low for 4; fft_in shows pairs 1,2,3,4 on consecutive cycles; m_valid high 4 cycles starting LATENCY cycles later, with m_sof on the first and m_eof on the last; frame_cnt=1.
REQ-038 Two pairs accepted, then clr pulse, then 4 new pairs -> only the 4 new pairs appear on fft_in, with no leftover data.
REQ-039 s_valid toggling every other cycle -> FILL stretches to 8 cycles, while BURST stays exactly 4 contiguous cycles.
REQ-040 en deasserted during BURST -> burst completes; s_ready stays 0 until en returns.
REQ-041 rst pulsed low during the third burst cycle -> all outputs 0 immediately; no m_valid afterwards; next frame processes normally.
REQ-042 256 back-to-back frames -> frame_cnt wraps to 0; busy never drops between frames once streaming is saturated.

Source files
------------

// File: rtl/fft_frame_ctrl_if.sv
// Stream bundle between upstream source, fft_frame_ctrl and the result sink.
// The slave view is the controller: it accepts pairs and emits qualified results.
interface fft_frame_ctrl_if #(
  parameter int unsigned NBITS = 10
);
  logic               s_valid;
  logic               s_ready;
  logic [2*NBITS-1:0] s_up;
  logic [2*NBITS-1:0] s_down;
  logic               m_valid;
  logic               m_sof;
  logic               m_eof;
  logic [2*NBITS-1:0] m_up;
  logic [2*NBITS-1:0] m_down;

  modport slave (
    input  s_valid, s_up, s_down,
    output s_ready, m_valid, m_sof, m_eof, m_up, m_down
  );

  modport master (
    output s_valid, s_up, s_down,
    input  s_ready, m_valid, m_sof, m_eof, m_up, m_down
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame controller for a streaming FFT core: buffers N/2 input pairs, bursts them into
// the core on consecutive cycles and tags the core's results with valid/sof/eof.
module fft_frame_ctrl #(
  parameter int unsigned NBITS   = 10,
  parameter int unsigned N       = 8,
  parameter int unsigned LATENCY = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  fft_frame_ctrl_if.slave    bus,
  output logic [2*NBITS-1:0] fft_in_up,
  output logic [2*NBITS-1:0] fft_in_down,
  input  logic [2*NBITS-1:0] fft_out_up,
  input  logic [2*NBITS-1:0] fft_out_down,
  output logic [7:0]         frame_cnt,
  output logic               busy
);

  localparam int unsigned Half = N / 2;
  localparam int unsigned PtrW = $clog2(Half);
  localparam int unsigned SW   = 2 * NBITS;

  localparam logic [PtrW-1:0] LastIdx = PtrW'(Half - 1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  typedef enum logic {StFill, StBurst} state_e;

  typedef struct packed {
    logic v;
    logic sof;
    logic eof;
  } tag_t;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [2*SW-1:0]       frame_buf_q [Half];
  logic [SW-1:0]         fft_in_up_q, fft_in_up_d;
  logic [SW-1:0]         fft_in_down_q, fft_in_down_d;
  tag_t                  in_tag_q, in_tag_d;
  tag_t [LATENCY-1:0]    tag_pipe_q, tag_pipe_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic                  wr_en;
  logic [2*SW-1:0]       rd_pair;
  logic                  pipe_busy;

  assign bus.s_ready = (state_q == StFill) && en && !clr;
  assign wr_en       = bus.s_valid && bus.s_ready;
  assign rd_pair     = frame_buf_q[rd_ptr_q];

  // Frame buffer holds data only; pointers and state decide what is meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      frame_buf_q[wr_ptr_q] <= {bus.s_up, bus.s_down};
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fft_in_up_d   = '0;
    fft_in_down_d = '0;
    in_tag_d      = '0;
    case (state_q)
      StFill: begin
        if (clr) begin
          wr_ptr_d = '0;
        end else if (wr_en) begin
          if (wr_ptr_q == LastIdx) begin
            state_d  = StBurst;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + PtrOne;
          end
        end
      end
      StBurst: begin
        {fft_in_up_d, fft_in_down_d} = rd_pair;
        in_tag_d.v   = 1'b1;
        in_tag_d.sof = (rd_ptr_q == '0);
        in_tag_d.eof = (rd_ptr_q == LastIdx);
        if (rd_ptr_q == LastIdx) begin
          state_d  = StFill;
          rd_ptr_d = '0;
        end else begin
          rd_ptr_d = rd_ptr_q + PtrOne;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Tag delay line mirrors the core pipeline so qualifiers line up with fft_out.
  always_comb begin
    tag_pipe_d[0] = in_tag_q;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      pipe_busy = pipe_busy | tag_pipe_q[i].v;
    end
  end

  assign frame_cnt_d = frame_cnt_q + {7'd0, bus.m_valid & bus.m_eof};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StFill;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fft_in_up_q   <= '0;
      fft_in_down_q <= '0;
      in_tag_q      <= '0;
      tag_pipe_q    <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fft_in_up_q   <= fft_in_up_d;
      fft_in_down_q <= fft_in_down_d;
      in_tag_q      <= in_tag_d;
      tag_pipe_q    <= tag_pipe_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign fft_in_up   = fft_in_up_q;
  assign fft_in_down = fft_in_down_q;
  assign bus.m_valid = tag_pipe_q[LATENCY-1].v;
  assign bus.m_sof   = tag_pipe_q[LATENCY-1].sof;
  assign bus.m_eof   = tag_pipe_q[LATENCY-1].eof;
  assign bus.m_up    = fft_out_up;
  assign bus.m_down  = fft_out_down;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = (state_q == StBurst) || in_tag_q.v || pipe_busy;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: randomized and directed stimulus against a frame-level model
// built from queues of accepted pairs and a per-cycle map of emitted tags.
module tb_fft_frame_ctrl;

  localparam int unsigned NBITS   = 10;
  localparam int unsigned N       = 8;
  localparam int unsigned LATENCY = 6;
  localparam int unsigned Half    = N / 2;
  localparam int unsigned W       = 2 * NBITS;

  typedef logic [2*W-1:0] pair_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] fft_in_up, fft_in_down;
  logic [W-1:0] fft_out_up = '0;
  logic [W-1:0] fft_out_down = '0;
  logic [7:0]   frame_cnt;
  logic         busy;

  fft_frame_ctrl_if #(.NBITS(NBITS)) bus ();

  fft_frame_ctrl #(.NBITS(NBITS), .N(N), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clr          (clr),
    .bus          (bus),
    .fft_in_up    (fft_in_up),
    .fft_in_down  (fft_in_down),
    .fft_out_up   (fft_out_up),
    .fft_out_down (fft_out_down),
    .frame_cnt    (frame_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- frame-level reference model ----------------
  pair_t      acc[$];
  pair_t      burst[$];
  logic [2:0] emit_tag[int];
  int         cyc      = 0;
  int         last_v   = -1000;
  pair_t      exp_fin  = '0;
  logic [2:0] exp_m    = '0;
  logic [7:0] exp_cnt  = '0;
  logic       exp_fill = 1'b1;
  logic       exp_busy = 1'b0;

  function automatic logic [2:0] tag_at(input int c);
    if (emit_tag.exists(c)) return emit_tag[c];
    return 3'b000;
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [2:0] m_now;
    pair_t      p;
    logic       sof;
    if (!rst) begin
      acc.delete();
      burst.delete();
      emit_tag.delete();
      last_v   = -1000;
      exp_fin  = '0;
      exp_m    = '0;
      exp_cnt  = '0;
      exp_fill = 1'b1;
      exp_busy = 1'b0;
    end else begin
      m_now = tag_at(cyc - int'(LATENCY));
      if (m_now[2] && m_now[0]) exp_cnt = exp_cnt + 8'd1;
      cyc++;
      if (burst.size() > 0) begin
        sof = (burst.size() == int'(Half));
        p   = burst.pop_front();
        exp_fin = p;
        emit_tag[cyc] = {1'b1, sof, burst.size() == 0};
        last_v = cyc;
      end else begin
        exp_fin = '0;
        if (clr) begin
          acc.delete();
        end else if (en && bus.s_valid) begin
          acc.push_back({bus.s_up, bus.s_down});
          if (acc.size() == int'(Half)) begin
            burst = acc;
            acc.delete();
          end
        end
      end
      exp_fill = (burst.size() == 0);
      exp_m    = tag_at(cyc - int'(LATENCY));
      exp_busy = !exp_fill || (last_v >= cyc - int'(LATENCY));
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    chk("s_ready", {31'd0, bus.s_ready}, {31'd0, exp_fill && en && !clr});
    chk("fft_in_up", {12'd0, fft_in_up}, {12'd0, exp_fin[2*W-1:W]});
    chk("fft_in_down", {12'd0, fft_in_down}, {12'd0, exp_fin[W-1:0]});
    chk("m_tag", {29'd0, bus.m_valid, bus.m_sof, bus.m_eof}, {29'd0, exp_m});
    chk("m_up", {12'd0, bus.m_up}, {12'd0, fft_out_up});
    chk("m_down", {12'd0, bus.m_down}, {12'd0, fft_out_down});
    chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    fft_out_up   = W'($urandom);
    fft_out_down = W'($urandom);
  endtask

  task automatic drive(input logic e, input logic c, input logic v,
                       input logic [W-1:0] u, input logic [W-1:0] d);
    en          = e;
    clr         = c;
    bus.s_valid = v;
    bus.s_up    = u;
    bus.s_down  = d;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();
    rst = 1'b1;

    // One clean frame of pairs 1..4
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, W'(i), W'(i + 100));
      #1 chk("dir_ready_fill", {31'd0, bus.s_ready}, 32'd1);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    #1 chk("dir_ready_burst", {31'd0, bus.s_ready}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("dir_fin_up", {12'd0, fft_in_up}, 32'(i));
      chk("dir_fin_down", {12'd0, fft_in_down}, 32'(i + 100));
    end
    repeat (LATENCY - 3) tick();
    chk("dir_sof", {29'd0, bus.m_valid, bus.m_sof, bus.m_eof}, 32'b110);
    repeat (3) tick();
    chk("dir_eof", {29'd0, bus.m_valid, bus.m_sof, bus.m_eof}, 32'b101);
    tick();
    chk("dir_cnt", {24'd0, frame_cnt}, 32'd1);
    chk("dir_mv_off", {31'd0, bus.m_valid}, 32'd0);

    // Two pairs, clr, four fresh pairs: only the fresh ones are bursted
    drive(1'b1, 1'b0, 1'b1, W'(7), W'(8));
    tick();
    tick();
    drive(1'b1, 1'b1, 1'b1, W'(9), W'(9));
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, W'(50 + k), W'(150 + k));
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    tick();
    chk("clr_first", {12'd0, fft_in_up}, 32'd50);
    repeat (LATENCY + 4) tick();

    // Reset during the third burst cycle
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, W'(60 + k), W'(160 + k));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_fin", {12'd0, fft_in_up}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cnt", {24'd0, frame_cnt}, 32'd0);
    tick();
    rst = 1'b1;

    // Toggling s_valid stretches FILL; en toggles across bursts
    for (int i = 0; i < 200; i++) begin
      drive(1'(i % 13 != 0), 1'b0, 1'(i % 2), W'($urandom), W'($urandom));
      tick();
    end

    // Randomized traffic with occasional clr and reset pulses
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      tick();
    end

    // 256 back-to-back frames from a clean reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      drive(1'b1, 1'b0, 1'b1, W'($urandom), W'($urandom));
      tick();
      if (i == 1023) chk("stream_cnt_mid", {24'd0, frame_cnt}, 32'd127);
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (LATENCY + 2) tick();
    chk("stream_cnt_wrap", {24'd0, frame_cnt}, 32'd0);
    chk("stream_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
